// File: rtl/dmac_request_generator_pkg.sv
// Shared types and Gray-code helper for the DMAC burst request generator.
package dmac_request_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } req_state_t;

    // Gray-code increment of a w-bit ID (w < 32), wrapping modulo 2^w.
    function automatic logic [31:0] inc_id(input logic [31:0] gray, input int unsigned w);
        logic [31:0] mask;
        logic [31:0] g;
        logic [31:0] bin;
        mask = (32'd1 << w) - 32'd1;
        g    = gray & mask;
        bin  = '0;
        for (int i = 0; i < 32; i++) begin
            bin[i] = ^(g >> i);
        end
        bin = (bin + 32'd1) & mask;
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/dmac_request_generator.sv
// Splits a transfer request into 16-beat burst slots by advancing a Gray-coded
// request_id, bounded by the data mover's returned response_id.
module dmac_request_generator
    import dmac_request_generator_pkg::*;
#(
    parameter int C_ID_WIDTH                  = 3,
    parameter int C_BURSTS_PER_TRANSFER_WIDTH = 17
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_aresetn,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [C_BURSTS_PER_TRANSFER_WIDTH-1:0] req_burst_count,
    input  logic                                   enable,
    output logic                                   enabled,
    input  logic                                   pause,
    output logic [C_ID_WIDTH-1:0]                  request_id,
    input  logic [C_ID_WIDTH-1:0]                  response_id,
    output logic                                   eot
);

    localparam int IW = C_ID_WIDTH;
    localparam int BW = C_BURSTS_PER_TRANSFER_WIDTH;

    req_state_t    state_reg, state_next;
    logic [BW-1:0] burst_count_reg, burst_count_next;
    logic [IW-1:0] request_id_reg, request_id_next;
    logic          enabled_reg, enabled_next;

    logic [IW-1:0] request_id_inc;
    logic [IW-1:0] response_id_inc;
    logic          ids_equal;
    logic          id_space_full;

    assign request_id_inc  = IW'(inc_id(32'(request_id_reg), IW));
    assign response_id_inc = IW'(inc_id(32'(response_id), IW));
    assign ids_equal       = (response_id == request_id_reg);
    // One slot is always kept free so a full ID space is distinguishable from empty.
    assign id_space_full   = (request_id_inc == response_id);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_reg       <= ST_IDLE;
            burst_count_reg <= '0;
            request_id_reg  <= '0;
            enabled_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            burst_count_reg <= burst_count_next;
            request_id_reg  <= request_id_next;
            enabled_reg     <= enabled_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        burst_count_next = burst_count_reg;
        request_id_next  = request_id_reg;
        enabled_next     = enabled_reg;

        if (enable) begin
            enabled_next = 1'b1;
        end else if (ids_equal) begin
            enabled_next = 1'b0;
        end

        // Once disabled and drained, abandon whatever is left of the transfer.
        if (!enable && ids_equal) begin
            state_next       = ST_IDLE;
            burst_count_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && enabled_reg) begin
                        state_next       = ST_BUSY;
                        burst_count_next = req_burst_count;
                    end
                end
                ST_BUSY: begin
                    if (enable && !pause && !id_space_full) begin
                        request_id_next = request_id_inc;
                        if (burst_count_reg == '0) begin
                            state_next = ST_DRAIN;
                        end else begin
                            burst_count_next = burst_count_reg - BW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ids_equal) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_reg == ST_IDLE) && enabled_reg;
    assign enabled    = enabled_reg;
    assign request_id = request_id_reg;
    // Final burst is the only one left between response_id and request_id.
    assign eot        = (state_reg == ST_DRAIN) && (response_id_inc == request_id_reg);

endmodule

// File: tb/tb_dmac_request_generator.sv
// Directed and random stimulus for dmac_request_generator, checked each cycle
// against a burst-counting reference model.
module tb_dmac_request_generator;

    localparam int IW = 3;
    localparam int BW = 17;
    localparam int MAX_OUT = (1 << IW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [BW-1:0] req_burst_count;
    logic          enable;
    logic          enabled;
    logic          pause;
    logic [IW-1:0] request_id;
    logic [IW-1:0] response_id;
    logic          eot;

    int errors = 0;
    int checks = 0;

    // Reference model: plain counts of bursts issued / completed since reset.
    int issued_m;
    int resp_m;
    int to_issue_m;
    bit in_xfer_m;
    bit enabled_m;

    always #5 clk = ~clk;

    dmac_request_generator #(
        .C_ID_WIDTH                 (IW),
        .C_BURSTS_PER_TRANSFER_WIDTH(BW)
    ) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_burst_count(req_burst_count),
        .enable         (enable),
        .enabled        (enabled),
        .pause          (pause),
        .request_id     (request_id),
        .response_id    (response_id),
        .eot            (eot)
    );

    function automatic logic [IW-1:0] gray(input int b);
        logic [IW-1:0] t;
        t = IW'(b);
        return t ^ (t >> 1);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (issued=%0d resp=%0d)",
                   tag, obs, exp, issued_m, resp_m);
        end
    endtask

    task automatic model_reset();
        issued_m   = 0;
        resp_m     = 0;
        to_issue_m = 0;
        in_xfer_m  = 1'b0;
        enabled_m  = 1'b0;
    endtask

    // Called just after a negedge with inputs already applied.
    task automatic cycle();
        int  outstanding;
        bit  empty;
        bit  can_issue;
        #1;
        outstanding = issued_m - resp_m;
        check("request_id", 8'(request_id), 8'(gray(issued_m)));
        check("req_ready", 8'(req_ready), 8'(!in_xfer_m && enabled_m));
        check("enabled", 8'(enabled), 8'(enabled_m));
        check("eot", 8'(eot), 8'(in_xfer_m && to_issue_m == 0 && outstanding == 1));
        if (rst_n) begin
            empty     = (outstanding == 0);
            can_issue = enable && !pause && (outstanding < MAX_OUT);
            if (!enable && empty) begin
                in_xfer_m  = 1'b0;
                to_issue_m = 0;
            end else if (!in_xfer_m) begin
                if (req_valid && enabled_m) begin
                    in_xfer_m  = 1'b1;
                    to_issue_m = int'(req_burst_count) + 1;
                end
            end else if (to_issue_m > 0) begin
                if (can_issue) begin
                    issued_m++;
                    to_issue_m--;
                end
            end else if (empty) begin
                in_xfer_m = 1'b0;
            end
            if (enable) enabled_m = 1'b1;
            else if (empty) enabled_m = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit en, input bit pa, input bit rv, input int cnt, input bit adv);
        enable          = en;
        pause           = pa;
        req_valid       = rv;
        req_burst_count = BW'(cnt);
        if (adv && resp_m < issued_m) resp_m++;
        response_id = gray(resp_m);
        cycle();
    endtask

    task automatic drain(input int adv_pct);
        int n = 0;
        while (in_xfer_m && n < 400) begin
            drive(1'b1, 1'b0, 1'b0, 0, $urandom_range(0, 99) < adv_pct);
            n++;
        end
        check("drain_ready", 8'(req_ready), 8'd1);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        enable = 1'b0; pause = 1'b0; req_valid = 1'b0;
        req_burst_count = '0; response_id = '0;
        @(negedge clk);
        repeat (2) cycle();
        rst_n = 1'b1;

        // Enable, then a three-burst transfer: IDs 0->1->3->2.
        repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drain(100);

        // ID space full: 21 bursts, data mover stuck, then one step at a time.
        drive(1'b1, 1'b0, 1'b1, 20, 1'b0);
        repeat (12) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drain(70);

        // Single burst.
        drive(1'b1, 1'b0, 1'b1, 0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drain(100);

        // Pause mid-transfer for 5 cycles.
        drive(1'b1, 1'b0, 1'b1, 10, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
        repeat (5) drive(1'b1, 1'b1, 1'b0, 0, 1'b1);
        drain(80);

        // Disable with bursts outstanding, drain, re-enable and continue IDs.
        drive(1'b1, 1'b0, 1'b1, 10, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (6) drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 4, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3, 1'b0);
        drain(60);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 12),
                  $urandom_range(0, 9) < 6);
        end
        drain(80);

        // Asynchronous reset between clock edges in the middle of a transfer.
        drive(1'b1, 1'b0, 1'b1, 5, 1'b0);
        enable = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_id_nonzero", 8'(request_id != '0), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_request_id", 8'(request_id), 8'd0);
        check("async_req_ready", 8'(req_ready), 8'd0);
        check("async_enabled", 8'(enabled), 8'd0);
        check("async_eot", 8'(eot), 8'd0);
        model_reset();
        response_id = '0;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2, 1'b0);
        drain(70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
